// File: rtl/mc_control_unit_pkg.sv
// mc_control_unit_pkg: shared opcodes, state encoding and decoded field bundle
package mc_control_unit_pkg;
  typedef enum logic [2:0] {FETCH, DECODE, EXECUTE, MEM, WB, HALT, TRAP} state_t;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_I      = 5'b00100;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_R      = 5'b01100;
  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_SYSTEM = 5'b11100;
  localparam logic [1:0] ALU_BR    = 2'b01;
  localparam logic [1:0] ALU_R     = 2'b10;
  localparam logic [1:0] ALU_I     = 2'b11;
  localparam logic [1:0] RD_PC_IMM = 2'b01;
  localparam logic [1:0] RD_PC4    = 2'b10;
  localparam logic [1:0] RD_IMM    = 2'b11;
  typedef struct packed {
    logic       legal;
    logic       system;
    logic       is_load;
    logic       is_store;
    logic       branch;
    logic       mem_to_reg;
    logic       alu_src;
    logic       pc_gen_sel;
    logic [1:0] alu_op;
    logic [1:0] rd_sel;
  } fields_t;
endpackage

// File: rtl/mc_control_unit_if.sv
// mc_control_unit_if: opcode/memory handshake and datapath control bundle
interface mc_control_unit_if #(parameter int CNT_W = 32);
  logic [4:0]       opcode;
  logic             mem_ready;
  logic             mem_req, iord, ir_write, pc_write;
  logic             branch, memRead, memtoReg, memWrite, ALUSrc, RegWrite, pc_gen_sel;
  logic [1:0]       ALUOp, rd_sel;
  logic             halted, illegal, bus_err;
  logic [2:0]       state;
  logic [CNT_W-1:0] instret;
  modport master (
    input  opcode, mem_ready,
    output mem_req, iord, ir_write, pc_write, branch, memRead, memtoReg, memWrite,
           ALUSrc, RegWrite, pc_gen_sel, ALUOp, rd_sel, halted, illegal, bus_err, state, instret
  );
  modport slave (
    output opcode, mem_ready,
    input  mem_req, iord, ir_write, pc_write, branch, memRead, memtoReg, memWrite,
           ALUSrc, RegWrite, pc_gen_sel, ALUOp, rd_sel, halted, illegal, bus_err, state, instret
  );
endinterface

// File: rtl/mc_control_unit_decode.sv
// mc_control_unit_decode: combinational opcode -> datapath field table and legality
module mc_control_unit_decode
  import mc_control_unit_pkg::*;
(
  input  logic [4:0] op,
  output fields_t    f
);
  always_comb begin
    f = '0;
    f.legal = 1'b1;
    case (op)
      OP_R:      f.alu_op = ALU_R;
      OP_I:      begin f.alu_op = ALU_I; f.alu_src = 1'b1; end
      OP_LOAD:   begin f.is_load = 1'b1; f.mem_to_reg = 1'b1; f.alu_src = 1'b1; end
      OP_STORE:  begin f.is_store = 1'b1; f.alu_src = 1'b1; end
      OP_BRANCH: begin f.branch = 1'b1; f.alu_op = ALU_BR; end
      OP_JALR:   begin f.alu_src = 1'b1; f.pc_gen_sel = 1'b1; f.rd_sel = RD_PC4; end
      OP_JAL:    f.rd_sel = RD_PC4;
      OP_AUIPC:  f.rd_sel = RD_PC_IMM;
      OP_LUI:    f.rd_sel = RD_IMM;
      OP_SYSTEM: begin f.legal = 1'b0; f.system = 1'b1; end
      default:   f.legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/mc_control_unit.sv
// mc_control_unit: multicycle control FSM with memory timeout and retired-instruction count
module mc_control_unit
  import mc_control_unit_pkg::*;
#(
  parameter int unsigned MEM_TIMEOUT = 255,
  parameter int unsigned CNT_W       = 32
) (
  input logic               clk,
  input logic               rst,
  mc_control_unit_if.master bus
);
  localparam int TW = $clog2(MEM_TIMEOUT + 2);
  state_t           state, state_n;
  logic [4:0]       op_q;
  logic [TW-1:0]    wait_cnt;
  logic [CNT_W-1:0] instret_q;
  logic             halted_q, illegal_q, bus_err_q;
  logic             mem_phase, ready, waiting, timeout, active, pc_write_c;
  fields_t          f;

  // while decoding, the live IR drives the table so legality is known before op_q loads
  mc_control_unit_decode u_decode (.op(state == DECODE ? bus.opcode : op_q), .f(f));

  always_comb begin
    mem_phase  = state == FETCH || state == MEM;
    ready      = mem_phase && bus.mem_ready;
    waiting    = mem_phase && !bus.mem_ready;
    timeout    = MEM_TIMEOUT != 0 && waiting && 32'(wait_cnt) + 1 >= MEM_TIMEOUT;
    active     = state == EXECUTE || state == MEM || state == WB;
    pc_write_c = !rst && ((state == EXECUTE && f.branch) || (state == MEM && f.is_store && ready) || state == WB);
  end

  always_ff @(posedge clk)
    state <= rst ? FETCH : state_n;

  always_comb begin
    state_n = state;
    case (state)
      FETCH:   state_n = ready ? DECODE : timeout ? TRAP : FETCH;
      DECODE:  state_n = f.system ? HALT : f.legal ? EXECUTE : TRAP;
      EXECUTE: state_n = f.branch ? FETCH : (f.is_load || f.is_store) ? MEM : WB;
      MEM:     state_n = ready ? (f.is_store ? FETCH : WB) : timeout ? TRAP : MEM;
      WB:      state_n = FETCH;
      default: state_n = state;
    endcase
  end

  // wait counter restarts on every state change, so each FETCH/MEM visit gets a fresh budget
  always_ff @(posedge clk) begin
    if (rst) begin
      op_q      <= '0;
      wait_cnt  <= '0;
      instret_q <= '0;
      halted_q  <= 1'b0;
      illegal_q <= 1'b0;
      bus_err_q <= 1'b0;
    end else begin
      if (state == DECODE) op_q <= bus.opcode;
      wait_cnt  <= state_n != state ? '0 : wait_cnt + TW'(waiting);
      if (pc_write_c) instret_q <= instret_q + CNT_W'(1);
      halted_q  <= halted_q || (state == DECODE && f.system);
      illegal_q <= illegal_q || (state == DECODE && !f.system && !f.legal);
      bus_err_q <= bus_err_q || timeout;
    end
  end

  always_comb begin
    bus.mem_req    = !rst && mem_phase;
    bus.iord       = state == MEM;
    bus.ir_write   = !rst && state == FETCH && bus.mem_ready;
    bus.pc_write   = pc_write_c;
    bus.RegWrite   = !rst && state == WB;
    bus.memRead    = !rst && state == MEM && f.is_load;
    bus.memWrite   = !rst && state == MEM && f.is_store;
    bus.branch     = active && f.branch;
    bus.memtoReg   = active && f.mem_to_reg;
    bus.ALUSrc     = active && f.alu_src;
    bus.pc_gen_sel = active && f.pc_gen_sel;
    bus.ALUOp      = active ? f.alu_op : '0;
    bus.rd_sel     = active ? f.rd_sel : '0;
    bus.halted     = halted_q;
    bus.illegal    = illegal_q;
    bus.bus_err    = bus_err_q;
    bus.state      = state;
    bus.instret    = instret_q;
  end
endmodule
